// File: rtl/reanimator_multi.sv
// rtl/reanimator_multi.sv - multi-channel reanimator: counts stimulus rising edges while the plant is DEAD
// and emits a registered one-cycle pulse at the limit, followed by a lockout.
module reanimator_multi #(
  parameter int          NUM_CH          = 2,
  parameter int          COUNTER_WIDTH   = 4,
  parameter int          COUNTER_LIMIT   = 4,
  parameter logic [1:0]  DEAD_STATE      = 2'b11,
  parameter int          DECAY_CYCLES    = 16,
  parameter int          COOLDOWN_CYCLES = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        stimulus,
  input  logic [1:0]               state,
  output logic [COUNTER_WIDTH-1:0] count,
  output logic                     reanimated,
  output logic                     busy
);

  localparam int NW  = $clog2(NUM_CH + 1);
  // Wide enough that count + popcount can never wrap before saturation.
  localparam int SW  = COUNTER_WIDTH + NW;
  localparam int DW  = (DECAY_CYCLES > 0) ? $clog2(DECAY_CYCLES + 1) : 1;
  localparam int CDW = (COOLDOWN_CYCLES > 0) ? $clog2(COOLDOWN_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_FIRE, S_COOL} fsm_t;

  fsm_t                     fsm_q, fsm_d;
  logic [NUM_CH-1:0]        stim_q;
  logic [COUNTER_WIDTH-1:0] count_q, count_d;
  logic [DW-1:0]            dtmr_q, dtmr_d;
  logic [CDW-1:0]           ctmr_q, ctmr_d;
  logic                     fire_q, busy_q;
  logic [NUM_CH-1:0]        edge_w;
  logic [NW-1:0]            n_w;
  logic [SW-1:0]            sum_w;

  always_comb begin
    edge_w = stimulus & ~stim_q;
    n_w    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      n_w = n_w + NW'(edge_w[i]);
    end
    sum_w = SW'(count_q) + SW'(n_w);
  end

  always_comb begin
    fsm_d   = fsm_q;
    count_d = count_q;
    dtmr_d  = dtmr_q;
    ctmr_d  = ctmr_q;
    case (fsm_q)
      S_IDLE: begin
        count_d = '0;
        dtmr_d  = '0;
        ctmr_d  = '0;
        if (state == DEAD_STATE) fsm_d = S_ARMED;
      end
      S_ARMED: begin
        if (state != DEAD_STATE) begin
          fsm_d   = S_IDLE;
          count_d = '0;
          dtmr_d  = '0;
        end else if (n_w != '0) begin
          dtmr_d = '0;
          if (sum_w >= SW'(COUNTER_LIMIT)) begin
            count_d = COUNTER_WIDTH'(COUNTER_LIMIT);
            fsm_d   = S_FIRE;
          end else begin
            count_d = sum_w[COUNTER_WIDTH-1:0];
          end
        end else if (DECAY_CYCLES > 0) begin
          if (dtmr_q == DW'(DECAY_CYCLES - 1)) begin
            dtmr_d = '0;
            if (count_q != '0) count_d = count_q - COUNTER_WIDTH'(1);
          end else begin
            dtmr_d = dtmr_q + DW'(1);
          end
        end
      end
      S_FIRE: begin
        count_d = '0;
        dtmr_d  = '0;
        ctmr_d  = '0;
        fsm_d   = (COOLDOWN_CYCLES > 0) ? S_COOL : S_IDLE;
      end
      S_COOL: begin
        count_d = '0;
        if (ctmr_q == CDW'(COOLDOWN_CYCLES - 1)) begin
          ctmr_d = '0;
          fsm_d  = S_IDLE;
        end else begin
          ctmr_d = ctmr_q + CDW'(1);
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  // Pulse and busy are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= S_IDLE;
      stim_q  <= '0;
      count_q <= '0;
      dtmr_q  <= '0;
      ctmr_q  <= '0;
      fire_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      stim_q  <= stimulus;
      count_q <= count_d;
      dtmr_q  <= dtmr_d;
      ctmr_q  <= ctmr_d;
      fire_q  <= (fsm_d == S_FIRE);
      busy_q  <= (fsm_d == S_FIRE) || (fsm_d == S_COOL);
    end
  end

  assign count      = count_q;
  assign reanimated = fire_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_reanimator_multi.sv
// tb/tb_reanimator_multi.sv - self-checking bench for reanimator_multi with a behavioural reference model
module tb_reanimator_multi;
  localparam int         NUM_CH = 2;
  localparam int         CW     = 4;
  localparam int         LIMIT  = 4;
  localparam int         DECAY  = 16;
  localparam int         COOL   = 8;
  localparam logic [1:0] DEAD   = 2'b11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    stimulus = '0;
  logic [1:0]    state = DEAD;
  logic [CW-1:0] count;
  logic          reanimated;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;

  bit         m_armed, m_fire;
  int         m_cool, m_prog, m_quiet;
  logic [1:0] m_prev;

  always #5 clk = ~clk;

  reanimator_multi #(
    .NUM_CH(NUM_CH), .COUNTER_WIDTH(CW), .COUNTER_LIMIT(LIMIT),
    .DEAD_STATE(DEAD), .DECAY_CYCLES(DECAY), .COOLDOWN_CYCLES(COOL)
  ) dut (
    .clk(clk), .rst(rst), .stimulus(stimulus), .state(state),
    .count(count), .reanimated(reanimated), .busy(busy)
  );

  function automatic int popc(input logic [1:0] v);
    return int'(v[0]) + int'(v[1]);
  endfunction

  task automatic model_step(input logic [1:0] s, input logic [1:0] st, input logic r);
    int rises;
    if (r) begin
      m_armed = 0; m_fire = 0; m_cool = 0; m_prog = 0; m_quiet = 0; m_prev = '0;
      return;
    end
    rises  = popc(s & ~m_prev);
    m_prev = s;
    if (m_fire) begin
      m_fire = 0; m_prog = 0; m_cool = COOL;
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (!m_armed) begin
      m_prog = 0; m_quiet = 0;
      if (st == DEAD) m_armed = 1;
    end else if (st != DEAD) begin
      m_armed = 0; m_prog = 0; m_quiet = 0;
    end else if (rises > 0) begin
      m_quiet = 0;
      m_prog  = (m_prog + rises > LIMIT) ? LIMIT : m_prog + rises;
      if (m_prog == LIMIT) begin
        m_fire = 1; m_armed = 0;
      end
    end else if (DECAY > 0) begin
      m_quiet++;
      if (m_quiet == DECAY) begin
        m_quiet = 0;
        if (m_prog > 0) m_prog--;
      end
    end
  endtask

  task automatic cycle(input logic [1:0] s, input logic [1:0] st, input logic r);
    stimulus = s; state = st; rst = r;
    @(posedge clk);
    model_step(s, st, r);
    #1;
  endtask

  task automatic test_reset;
    cycle(2'b11, DEAD, 1'b1);
    cycle(2'b11, DEAD, 1'b1);
    n_checks++;
    if ({count, reanimated, busy} !== 6'b0)
      $display("FAIL reset: got cnt=%0d re=%0b busy=%0b want 0 0 0", count, reanimated, busy);
    else n_pass++;
  endtask

  task automatic test_single_channel;
    int fires = 0;
    cycle(2'b00, DEAD, 1'b0);
    for (int p = 0; p < 4; p++) begin
      cycle(2'b01, DEAD, 1'b0);
      n_checks++;
      if (p < 3 && {count, reanimated} !== {4'(p + 1), 1'b0})
        $display("FAIL single pulse%0d: got cnt=%0d re=%0b want %0d 0", p, count, reanimated, p + 1);
      else if (p == 3 && {reanimated, busy} !== 2'b11)
        $display("FAIL single fire: got re=%0b busy=%0b want 1 1", reanimated, busy);
      else n_pass++;
      for (int k = 0; k < 3; k++) begin
        cycle(2'b00, DEAD, 1'b0);
        if (p < 3 || k == 0) begin
          n_checks++;
          if (p < 3 && count !== 4'(p + 1))
            $display("FAIL single hold%0d: got cnt=%0d want %0d", p, count, p + 1);
          else if (p == 3 && {count, reanimated} !== 5'b0)
            $display("FAIL single after fire: got cnt=%0d re=%0b want 0 0", count, reanimated);
          else n_pass++;
        end
      end
    end
    for (int k = 0; k < 10; k++) begin
      cycle(2'b00, DEAD, 1'b0);
      if (reanimated) fires++;
    end
    n_checks++;
    if (fires != 0 || {count, busy} !== 5'b0)
      $display("FAIL single settle: got fires=%0d cnt=%0d busy=%0b want 0 0 0", fires, count, busy);
    else n_pass++;
  endtask

  task automatic test_saturate;
    int fires = 0;
    for (int p = 0; p < 3; p++) begin
      cycle(2'b01, DEAD, 1'b0);
      cycle(2'b00, DEAD, 1'b0);
    end
    n_checks++;
    if (count !== 4'd3) $display("FAIL sat pre: got cnt=%0d want 3", count);
    else n_pass++;
    cycle(2'b11, DEAD, 1'b0);
    n_checks++;
    if ({count, reanimated, busy} !== {4'd4, 1'b1, 1'b1})
      $display("FAIL sat fire: got cnt=%0d re=%0b busy=%0b want 4 1 1", count, reanimated, busy);
    else n_pass++;
    for (int k = 0; k < 12; k++) begin
      cycle(2'b00, DEAD, 1'b0);
      if (reanimated) fires++;
    end
    n_checks++;
    if (fires != 0 || count !== 4'd0)
      $display("FAIL sat single pulse: got extra=%0d cnt=%0d want 0 0", fires, count);
    else n_pass++;
  endtask

  task automatic test_held_level;
    for (int k = 0; k < 10; k++) begin
      cycle(2'b01, DEAD, 1'b0);
      n_checks++;
      if ({count, reanimated} !== {4'd1, 1'b0})
        $display("FAIL held cyc%0d: got cnt=%0d re=%0b want 1 0", k, count, reanimated);
      else n_pass++;
    end
    cycle(2'b00, 2'b00, 1'b0);
    cycle(2'b00, DEAD, 1'b0);
  endtask

  task automatic test_decay;
    cycle(2'b01, DEAD, 1'b0); cycle(2'b00, DEAD, 1'b0);
    cycle(2'b01, DEAD, 1'b0); cycle(2'b00, DEAD, 1'b0);
    cycle(2'b01, DEAD, 1'b0);
    for (int i = 1; i <= 32; i++) begin
      cycle(2'b00, DEAD, 1'b0);
      if (i == 15 || i == 16 || i == 31 || i == 32) begin
        n_checks++;
        if (count !== 4'(i < 16 ? 3 : (i < 32 ? 2 : 1)))
          $display("FAIL decay quiet%0d: got cnt=%0d want %0d", i, count, i < 16 ? 3 : (i < 32 ? 2 : 1));
        else n_pass++;
      end
    end
    cycle(2'b01, DEAD, 1'b0);
    for (int i = 0; i < 15; i++) cycle(2'b00, DEAD, 1'b0);
    n_checks++;
    if (count !== 4'd2) $display("FAIL decay hold2: got cnt=%0d want 2", count);
    else n_pass++;
    cycle(2'b01, DEAD, 1'b0);
    for (int i = 0; i < 15; i++) cycle(2'b00, DEAD, 1'b0);
    n_checks++;
    if (count !== 4'd3) $display("FAIL decay timer reset: got cnt=%0d want 3", count);
    else n_pass++;
    cycle(2'b01, DEAD, 1'b0);
    n_checks++;
    if ({count, reanimated} !== {4'd4, 1'b1})
      $display("FAIL decay fire: got cnt=%0d re=%0b want 4 1", count, reanimated);
    else n_pass++;
    for (int i = 0; i < 12; i++) cycle(2'b00, DEAD, 1'b0);
  endtask

  task automatic fire_quick;
    for (int p = 0; p < 4; p++) begin
      cycle(2'b01, DEAD, 1'b0);
      if (p < 3) cycle(2'b00, DEAD, 1'b0);
    end
  endtask

  task automatic test_cooldown;
    fire_quick();
    n_checks++;
    if (reanimated !== 1'b1) $display("FAIL cool fire: got re=%0b want 1", reanimated);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      cycle((i % 2 == 0) ? 2'b11 : 2'b00, (i == 3) ? 2'b00 : DEAD, 1'b0);
      n_checks++;
      if ({count, reanimated, busy} !== {4'd0, 1'b0, 1'b1})
        $display("FAIL cool cyc%0d: got cnt=%0d re=%0b busy=%0b want 0 0 1", i, count, reanimated, busy);
      else n_pass++;
    end
    cycle(2'b00, DEAD, 1'b0);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL cool end: got busy=%0b want 0", busy);
    else n_pass++;
    cycle(2'b00, DEAD, 1'b0);
    cycle(2'b01, DEAD, 1'b0);
    n_checks++;
    if (count !== 4'd1) $display("FAIL cool resume: got cnt=%0d want 1", count);
    else n_pass++;
    cycle(2'b00, 2'b00, 1'b0);
    cycle(2'b00, DEAD, 1'b0);
  endtask

  task automatic test_state_drop;
    cycle(2'b01, DEAD, 1'b0); cycle(2'b00, DEAD, 1'b0); cycle(2'b01, DEAD, 1'b0);
    n_checks++;
    if (count !== 4'd2) $display("FAIL drop pre: got cnt=%0d want 2", count);
    else n_pass++;
    cycle(2'b00, 2'b00, 1'b0);
    n_checks++;
    if ({count, reanimated, busy} !== 6'b0)
      $display("FAIL drop: got cnt=%0d re=%0b busy=%0b want 0 0 0", count, reanimated, busy);
    else n_pass++;
    cycle(2'b01, 2'b01, 1'b0);
    n_checks++;
    if (count !== 4'd0) $display("FAIL drop idle edge: got cnt=%0d want 0", count);
    else n_pass++;
    cycle(2'b00, DEAD, 1'b0);
  endtask

  task automatic test_reset_in_cooldown;
    fire_quick();
    for (int i = 0; i < 3; i++) cycle(2'b00, DEAD, 1'b0);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL rstcool pre: got busy=%0b want 1", busy);
    else n_pass++;
    cycle(2'b11, DEAD, 1'b1);
    n_checks++;
    if ({count, reanimated, busy} !== 6'b0)
      $display("FAIL rstcool: got cnt=%0d re=%0b busy=%0b want 0 0 0", count, reanimated, busy);
    else n_pass++;
    cycle(2'b00, DEAD, 1'b0);
  endtask

  task automatic test_random;
    logic [1:0] s = 2'b00;
    logic [1:0] st;
    logic       r;
    for (int i = 0; i < 1200; i++) begin
      if (i < 500 || $urandom_range(0, 19) == 0) s = 2'($urandom);
      st = ($urandom_range(0, 29) == 0) ? 2'($urandom) : DEAD;
      r  = ($urandom_range(0, 249) == 0);
      cycle(s, st, r);
      n_checks++;
      if ({count, reanimated, busy} !== {4'(m_prog), m_fire, (m_fire || m_cool > 0)})
        $display("FAIL rand cyc%0d: got cnt=%0d re=%0b busy=%0b want cnt=%0d re=%0b busy=%0b",
                 i, count, reanimated, busy, m_prog, m_fire, (m_fire || m_cool > 0));
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_saturate();
    test_held_level();
    test_decay();
    test_cooldown();
    test_state_drop();
    test_reset_in_cooldown();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
